// File: rtl/serial_pattern_tx.sv
// Serial pattern link transmitter: loads a WIDTH-bit word over valid/ready and
// shifts it out one bit per clock on x_o/x_valid_o, then pulses done_o.
module serial_pattern_tx #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1,
   parameter logic        IDLE_X    = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_valid_i,
   output logic             load_ready_o,
   input  logic [WIDTH-1:0] data_in_i,
   input  logic             abort_i,
   output logic             x_o,
   output logic             x_valid_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic             x_q, x_d;
   logic             x_valid_q, x_valid_d;
   logic             done_q, done_d;

   logic             first_bit_c;
   logic             next_bit_c;
   logic [WIDTH-1:0] sreg_shift_c;

   // sreg holds the word with the bit currently on x still at the head;
   // x is registered, so the next bit is always taken one position behind the head.
   always_comb begin
      first_bit_c  = MSB_FIRST ? data_in_i[WIDTH-1] : data_in_i[0];
      next_bit_c   = MSB_FIRST ? sreg_q[WIDTH-2] : sreg_q[1];
      sreg_shift_c = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sreg_d    = sreg_q;
      x_d       = x_q;
      x_valid_d = x_valid_q;
      done_d    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            x_d       = IDLE_X;
            x_valid_d = 1'b0;
            if (load_valid_i && !abort_i) begin
               state_d   = S_SHIFT;
               cnt_d     = '0;
               sreg_d    = data_in_i;
               x_d       = first_bit_c;
               x_valid_d = 1'b1;
            end
         end
         S_SHIFT: begin
            if (abort_i) begin
               state_d   = S_IDLE;
               x_d       = IDLE_X;
               x_valid_d = 1'b0;
            end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d   = S_DONE;
               x_d       = IDLE_X;
               x_valid_d = 1'b0;
               done_d    = 1'b1;
            end else begin
               x_d    = next_bit_c;
               sreg_d = sreg_shift_c;
               cnt_d  = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            state_d   = S_IDLE;
            x_d       = IDLE_X;
            x_valid_d = 1'b0;
         end
         default: begin
            state_d   = S_IDLE;
            x_d       = IDLE_X;
            x_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         sreg_q    <= '0;
         x_q       <= IDLE_X;
         x_valid_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sreg_q    <= sreg_d;
         x_q       <= x_d;
         x_valid_q <= x_valid_d;
         done_q    <= done_d;
      end
   end

   // load_ready is gated by rst combinationally so nothing is accepted during reset.
   assign load_ready_o = (state_q == S_IDLE) && !rst_i;
   assign busy_o       = (state_q != S_IDLE);
   assign x_o          = x_q;
   assign x_valid_o    = x_valid_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: MSB-first (IDLE_X=0) and LSB-first (IDLE_X=1)
// instances share stimulus and are checked against a per-frame bit-order model.
module tb_serial_pattern_tx;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         load_valid = 1'b0;
   logic [W-1:0] data_in = '0;
   logic         abort = 1'b0;

   logic load_ready_m, x_m, x_valid_m, busy_m, done_m;
   logic load_ready_l, x_l, x_valid_l, busy_l, done_l;

   int unsigned vectors = 0;
   int unsigned errors  = 0;
   logic [W-1:0] rx_seq;

   serial_pattern_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_X(1'b0)) dut_m (
      .clk_i(clk), .rst_i(rst), .load_valid_i(load_valid), .load_ready_o(load_ready_m),
      .data_in_i(data_in), .abort_i(abort), .x_o(x_m), .x_valid_o(x_valid_m),
      .busy_o(busy_m), .done_o(done_m));

   serial_pattern_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_X(1'b1)) dut_l (
      .clk_i(clk), .rst_i(rst), .load_valid_i(load_valid), .load_ready_o(load_ready_l),
      .data_in_i(data_in), .abort_i(abort), .x_o(x_l), .x_valid_o(x_valid_l),
      .busy_o(busy_l), .done_o(done_l));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Idle-level outputs of both instances, with expected load_ready.
   task automatic check_quiet(input string tag, input logic ready_exp);
      chk({tag, "_xv_m"}, 32'(x_valid_m), 32'd0);
      chk({tag, "_xv_l"}, 32'(x_valid_l), 32'd0);
      chk({tag, "_x_m"}, 32'(x_m), 32'd0);
      chk({tag, "_x_l"}, 32'(x_l), 32'd1);
      chk({tag, "_done"}, {30'd0, done_m, done_l}, 32'd0);
      chk({tag, "_busy"}, {30'd0, busy_m, busy_l}, 32'd0);
      chk({tag, "_ready"}, {30'd0, load_ready_m, load_ready_l}, ready_exp ? 32'd3 : 32'd0);
   endtask

   // Checks n frame bits starting at the current cycle, one per clock.
   task automatic check_bits(input logic [W-1:0] w, input int n, input bit noise);
      for (int i = 0; i < n; i++) begin
         chk($sformatf("bit%0d_x_m", i), 32'(x_m), 32'(w[W-1-i]));
         chk($sformatf("bit%0d_x_l", i), 32'(x_l), 32'(w[i]));
         chk($sformatf("bit%0d_xv", i), {30'd0, x_valid_m, x_valid_l}, 32'd3);
         chk($sformatf("bit%0d_done", i), {30'd0, done_m, done_l}, 32'd0);
         chk($sformatf("bit%0d_busy_rdy", i), {28'd0, busy_m, busy_l, load_ready_m, load_ready_l}, 32'hC);
         rx_seq[i] = x_m;
         if (noise) begin
            load_valid = 1'($urandom);
            data_in    = W'($urandom);
         end
         tick();
      end
   endtask

   task automatic check_done(input bit hold);
      chk("done_pulse", {30'd0, done_m, done_l}, 32'd3);
      chk("done_xv", {30'd0, x_valid_m, x_valid_l}, 32'd0);
      chk("done_x", {30'd0, x_m, x_l}, 32'd1);
      chk("done_busy_rdy", {28'd0, busy_m, busy_l, load_ready_m, load_ready_l}, 32'hC);
      if (!hold) load_valid = 1'b0;
      tick();
   endtask

   task automatic send_frame(input logic [W-1:0] w, input bit noise);
      int n = 0;
      while (!load_ready_m && n < 20) begin
         tick();
         n++;
      end
      chk("ready_wait", 32'(load_ready_m), 32'd1);
      data_in    = w;
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      data_in    = W'($urandom);
      check_bits(w, W, noise);
      check_done(1'b0);
      check_quiet("post_frame", 1'b1);
   endtask

   initial begin
      logic [W-1:0] w;
      logic [W-1:0] ymask;

      // Reset state, with load_ready gated low during reset.
      load_valid = 1'b1;
      data_in    = 8'h5A;
      tick();
      tick();
      check_quiet("reset", 1'b0);
      load_valid = 1'b0;
      rst = 1'b0;
      tick();
      check_quiet("after_reset", 1'b1);

      // Directed frames in both bit orders.
      send_frame(8'b1101_0011, 1'b0);
      send_frame(8'hA5, 1'b0);

      // load_valid held high: second word only accepted from IDLE.
      data_in    = 8'hFF;
      load_valid = 1'b1;
      tick();
      data_in = 8'h00;
      check_bits(8'hFF, W, 1'b0);
      check_done(1'b1);
      check_quiet("gap_idle", 1'b1);
      tick();
      load_valid = 1'b0;
      check_bits(8'h00, W, 1'b0);
      check_done(1'b0);
      check_quiet("held_end", 1'b1);

      // Abort on the 3rd bit.
      data_in    = 8'hF0;
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      check_bits(8'hF0, 2, 1'b0);
      chk("abort_3rd_xv", 32'(x_valid_m), 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_quiet("abort_next", 1'b1);
      tick();
      check_quiet("abort_after", 1'b1);

      // Abort in IDLE beats a simultaneous load.
      abort      = 1'b1;
      load_valid = 1'b1;
      data_in    = 8'hAA;
      tick();
      abort      = 1'b0;
      load_valid = 1'b0;
      check_quiet("abort_idle", 1'b1);

      // Abort while done is showing ends the DONE cycle normally.
      data_in    = 8'h81;
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      check_bits(8'h81, W, 1'b0);
      chk("abort_done_pulse", {30'd0, done_m, done_l}, 32'd3);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_quiet("abort_done", 1'b1);

      // Reset mid-frame discards the frame.
      data_in    = 8'h3C;
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      check_bits(8'h3C, 3, 1'b0);
      rst = 1'b1;
      tick();
      check_quiet("mid_reset", 1'b0);
      rst = 1'b0;
      tick();
      check_quiet("mid_reset_exit", 1'b1);
      send_frame(8'h96, 1'b0);

      // Loopback into a two-consecutive-ones detector.
      send_frame(8'b0110_0110, 1'b0);
      ymask = '0;
      for (int i = 1; i < int'(W); i++) ymask[i] = rx_seq[i] & rx_seq[i-1];
      chk("detector_y", 32'(ymask), 32'h44);

      // Random words, random idle gaps, junk loads during the frame.
      for (int k = 0; k < 16; k++) begin
         w = W'($urandom);
         for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
            tick();
            check_quiet("rand_gap", 1'b1);
         end
         send_frame(w, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
